// File: rtl/conv_window_feeder_if.sv
// Pair-stream bundle for conv_window_feeder: weight load port, sample port,
// flush control and the (sample, weight) pair output toward mult_reduce.
// The slave modport is the feeder's view; the master modport is the
// surrounding environment.
interface conv_window_feeder_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  weight_ready_in;
  logic                  weight_valid_in;
  logic [DATA_WIDTH-1:0] weight_data_in;
  logic                  sample_ready_in;
  logic                  sample_valid_in;
  logic [DATA_WIDTH-1:0] sample_data_in;
  logic                  flush_in;
  logic                  feeder_ready_out;
  logic                  feeder_valid_out;
  logic [DATA_WIDTH-1:0] feeder_dataa_out;
  logic [DATA_WIDTH-1:0] feeder_datab_out;
  logic                  feeder_last_out;

  modport slave (
    input  weight_valid_in, weight_data_in,
    input  sample_valid_in, sample_data_in,
    input  flush_in, feeder_ready_out,
    output weight_ready_in, sample_ready_in,
    output feeder_valid_out, feeder_dataa_out, feeder_datab_out, feeder_last_out
  );

  modport master (
    output weight_valid_in, weight_data_in,
    output sample_valid_in, sample_data_in,
    output flush_in, feeder_ready_out,
    input  weight_ready_in, sample_ready_in,
    input  feeder_valid_out, feeder_dataa_out, feeder_datab_out, feeder_last_out
  );
endinterface

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: holds KERNEL_SIZE weights and a stride-1 sliding window
// of the most recent KERNEL_SIZE samples, and streams each full window out as
// KERNEL_SIZE (sample, weight) pairs. All handshake outputs decode from
// registered state only, so there is no combinational path from any input.
module conv_window_feeder #(
  parameter int DATA_WIDTH  = 12,
  parameter int KERNEL_SIZE = 5
) (
  input logic                  clk,
  input logic                  rst,
  conv_window_feeder_if.slave  bus_io
);

  localparam int IDX_W = $clog2(KERNEL_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {
    LOAD_W = 2'd0,
    FILL   = 2'd1,
    EMIT   = 2'd2,
    ACCEPT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      fill_q, fill_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [DATA_WIDTH-1:0] w_q   [KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] win_q [KERNEL_SIZE];

  logic w_hs_s;
  logic s_hs_s;
  logic o_hs_s;

  // Handshakes are qualified by state because every ready/valid is a state decode.
  always_comb begin
    w_hs_s = (state_q == LOAD_W) && bus_io.weight_valid_in;
    s_hs_s = ((state_q == FILL) || (state_q == ACCEPT)) && bus_io.sample_valid_in;
    o_hs_s = (state_q == EMIT) && bus_io.feeder_ready_out;
  end

  // Next-state logic for the control FSM, tap index, fill count and deferred flush.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fill_d       = fill_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      LOAD_W: begin
        if (w_hs_s) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = FILL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      FILL, ACCEPT: begin
        if (bus_io.flush_in) begin
          // A sample taken with the flush becomes element 0 of the new window.
          state_d = FILL;
          fill_d  = s_hs_s ? IDX_W'(1) : {IDX_W{1'b0}};
        end else if (s_hs_s) begin
          if (state_q == ACCEPT) begin
            state_d = EMIT;
          end else if (fill_q == LAST_IDX) begin
            fill_d  = {IDX_W{1'b0}};
            state_d = EMIT;
          end else begin
            fill_d = fill_q + IDX_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      EMIT: begin
        if (bus_io.flush_in) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (o_hs_s) begin
          if (idx_q == LAST_IDX) begin
            idx_d = {IDX_W{1'b0}};
            if (flush_pend_q || bus_io.flush_in) begin
              state_d      = FILL;
              fill_d       = {IDX_W{1'b0}};
              flush_pend_d = 1'b0;
            end else begin
              state_d = ACCEPT;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d      = LOAD_W;
        idx_d        = {IDX_W{1'b0}};
        fill_d       = {IDX_W{1'b0}};
        flush_pend_d = 1'b0;
      end
    endcase
  end

  // Control registers; reset drops any partial window and pending flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD_W;
      idx_q        <= {IDX_W{1'b0}};
      fill_q       <= {IDX_W{1'b0}};
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Weight taps load by index; the window shifts toward element 0 on every sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        w_q[j]   <= {DATA_WIDTH{1'b0}};
        win_q[j] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (w_hs_s) begin
        w_q[idx_q] <= bus_io.weight_data_in;
      end
      if (s_hs_s) begin
        for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
          win_q[j] <= win_q[j+1];
        end
        win_q[KERNEL_SIZE-1] <= bus_io.sample_data_in;
      end
    end
  end

  // Output decode from registered state, index and data only.
  always_comb begin
    bus_io.weight_ready_in  = 1'b0;
    bus_io.sample_ready_in  = 1'b0;
    bus_io.feeder_valid_out = 1'b0;
    bus_io.feeder_last_out  = 1'b0;
    bus_io.feeder_dataa_out = {DATA_WIDTH{1'b0}};
    bus_io.feeder_datab_out = {DATA_WIDTH{1'b0}};
    case (state_q)
      LOAD_W: bus_io.weight_ready_in = 1'b1;
      FILL:   bus_io.sample_ready_in = 1'b1;
      ACCEPT: bus_io.sample_ready_in = 1'b1;
      EMIT: begin
        bus_io.feeder_valid_out = 1'b1;
        bus_io.feeder_dataa_out = win_q[idx_q];
        bus_io.feeder_datab_out = w_q[idx_q];
        bus_io.feeder_last_out  = (idx_q == LAST_IDX);
      end
      default: bus_io.weight_ready_in = 1'b0;
    endcase
  end

endmodule
